idu_pipe_stage: RTL
===================

Name: idu_pipe_stage

Overview:
- Parametrised successor to the decode-stage pipeline register, placed between IFU and EXU.
- Replaces "nop on hazard" with a valid/ready handshake, and replaces the single write-back forward with NWB forwarding ports.
- Adds a 31-entry scoreboard that interlocks RAW hazards on in-flight destinations; flush kills only the younger instructions held here.
- Decoder and immediate generator stay outside; their results arrive on in_ctrl and in_imm.

Parameters:
XLEN, 64, datapath width (32 or 64)
NWB, 2, number of write-back forwarding ports; port 0 has highest priority
CTRL_W, 24, width of the decoded control bundle passed through

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
flush  in  1  kill the instruction being captured and the one held in the output register
in_valid  in  1  IFU instruction valid
in_ready  out  1  stage accepts the instruction this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction PC
in_snxt_pc  in  XLEN  static next PC
in_imm  in  XLEN  generated immediate
in_ctrl  in  CTRL_W  decoded control bundle
in_need_rs1  in  1  instruction reads rs1
in_need_rs2  in  1  instruction reads rs2
in_wr_rd  in  1  instruction writes rd
rf_index_rs1  out  5  regfile read index, = in_instr[19:15]
rf_index_rs2  out  5  regfile read index, = in_instr[24:20]
rf_data_rs1  in  XLEN  regfile read data
rf_data_rs2  in  XLEN  regfile read data
wb_en  in  NWB  write-back valid per port
wb_index  in  NWB*5  write-back rd per port
wb_data  in  NWB*XLEN  write-back data per port
out_valid  out  1  output register valid
out_ready  in  1  EXU accepts
out_instr, out_pc, out_snxt_pc, out_imm, out_ctrl  out  as inputs  registered payload
out_index_rs1, out_index_rs2, out_index_rd  out  5  registered indices
out_wr_rd  out  1  registered write flag
out_data_rs1, out_data_rs2  out  XLEN  registered operands
hazard_stall  out  1  RAW interlock active this cycle

Behaviour:
- Reset (rstn low, asynchronous): all out_* = 0, out_valid = 0, every scoreboard bit = 0. Deassertion takes effect at the next clk edge.
- Forwarding, operand rsN:
  - Select wb_data[k] for the lowest k with wb_en[k] and wb_index[k] == rsN and rsN != 0; otherwise use rf_data_rsN.
  - rsN == 0 always yields 0.
- Scoreboard busy[r], r = 1..31:
  - Set at the edge where out_valid & out_ready & !flush & out_wr_rd & out_index_rd != 0, for r = out_index_rd.
  - Cleared at the edge where any wb_en[k] has wb_index[k] == r.
  - Set and clear of the same r in one cycle: set wins.
  - busy[0] is always 0.
- pend(r) = busy[r] & no wb port forwards r this cycle, OR (out_valid & out_wr_rd & out_index_rd == r & r != 0).
- hazard_stall = in_valid & ((in_need_rs1 & pend(rs1)) | (in_need_rs2 & pend(rs2))).
- in_ready = (!out_valid | out_ready) & !hazard_stall & !flush.
- in_fire = in_valid & in_ready.
- Output register update:
  - flush: out_valid <= 0; payload is don't-care; the scoreboard is not cleared, because older in-flight writes still complete.
  - Else if (!out_valid | out_ready): out_valid <= in_fire, and the payload (with forwarded operands) is loaded when in_fire.
  - Hazard with the output draining produces a bubble: out_valid = 0.
  - Else: hold all outputs.
- Latency is 1 cycle from in_fire to out_valid. Throughput is 1/cycle when there is no hazard.
- Payload is stable while out_valid & !out_ready.
- A load-use or back-to-back dependency stalls until the producer's write-back; the forwarded value is captured in the same cycle the write-back occurs.

Optional Feature:
- Macro IDU_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_stall_cnt[31:0] and perf_flush_cnt[31:0], both reset to 0.
  - perf_stall_cnt increments on each cycle with hazard_stall.
  - perf_flush_cnt increments on each cycle flush is high and out_valid was 1.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: XLEN default, REG_IDX_W = 5, NUM_GPR = 32, default CTRL_W, and the zero-register index constant.
- One sub-module, idu_scoreboard: busy vector, set/clear logic, NWB-port clear match. It outputs busy[31:0] and combinational pend(rs1)/pend(rs2) given the current out-register rd.

Test Plan:
- Pipelining: reset, then stream addi x1,x0,5 and addi x2,x0,7 with out_ready = 1 -> out_valid on cycles 1 and 2; out_imm = 5 then 7; no hazard_stall.
- Register-read dependency: issue add x3,x1,x2 with in_need_rs1 = 1 and busy[1] = 1 set by a prior write.
  - Hold wb idle 3 cycles -> hazard_stall = 1 and in_ready = 0 for 3 cycles, with bubbles on out.
  - Then wb_en[1] = 1, wb_index = 1, wb_data = 0x55 -> instruction captured that cycle with out_data_rs1 = 0x55.
- Port priority: wb_en = 2'b11, both ports index 4, data 0xAA on port 0 and 0xBB on port 1, rs2 = 4 -> out_data_rs2 = 0xAA. With rs2 = 0 -> 0.
- Backpressure: out_ready = 0 for 4 cycles with in_valid = 1 -> payload held constant and in_ready = 0. Release -> next instruction appears on the following cycle; no instruction is lost or duplicated.
- Flush:
  - flush pulse while out_valid = 1 and in_valid = 1 -> out_valid = 0 next cycle and the input is not accepted.
  - A busy bit set by an older instruction remains set until its wb.
- Reset mid-stall: assert rstn low asynchronously while hazard_stall = 1 -> out_valid and busy clear immediately, without waiting for a clk edge.
- With IDU_PERF_CNT_EN defined: perf_stall_cnt = 3 after the register-read dependency scenario.

Source files
------------

// File: rtl/idu_pipe_stage_pkg.sv
// Shared constants for the decode-stage pipeline register and its scoreboard.
package idu_pipe_stage_pkg;

  localparam int XLEN_DEF   = 64;
  localparam int CTRL_W_DEF = 24;
  localparam int REG_IDX_W  = 5;
  localparam int NUM_GPR    = 32;

  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/idu_scoreboard.sv
// RAW scoreboard: one busy bit per GPR (x0 never busy), set when a writer
// leaves toward EXU, cleared by any write-back port. Also reports whether
// a source register is still pending this cycle.
module idu_scoreboard
  import idu_pipe_stage_pkg::*;
#(
  parameter int NWB = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     set_en,
  input  logic [REG_IDX_W-1:0]     set_idx,
  input  logic [NWB-1:0]           wb_en,
  input  logic [NWB*REG_IDX_W-1:0] wb_index,
  input  logic                     out_valid,
  input  logic                     out_wr_rd,
  input  logic [REG_IDX_W-1:0]     out_rd,
  input  logic [REG_IDX_W-1:0]     rs1,
  input  logic [REG_IDX_W-1:0]     rs2,
  output logic [NUM_GPR-1:0]       busy,
  output logic                     pend_rs1,
  output logic                     pend_rs2
);

  logic [NUM_GPR-1:0] busy_q;
  logic [NUM_GPR-1:0] clr_p0;
  logic [NUM_GPR-1:0] set_p0;
  logic               out_hit_rs1_p0;
  logic               out_hit_rs2_p0;

  // Stage p0: decode write-back clears and the issuing writer's set
  always_comb begin
    clr_p0 = '0;
    set_p0 = '0;
    for (int k = 0; k < NWB; k++) begin
      if (wb_en[k]) begin
        clr_p0[wb_index[k*REG_IDX_W +: REG_IDX_W]] = 1'b1;
      end
    end
    if (set_en) begin
      set_p0[set_idx] = 1'b1;
    end
  end

  assign out_hit_rs1_p0 = out_valid && out_wr_rd && (out_rd == rs1) && (rs1 != ZERO_REG);
  assign out_hit_rs2_p0 = out_valid && out_wr_rd && (out_rd == rs2) && (rs2 != ZERO_REG);

  // A write-back landing this cycle is forwarded, so it does not block
  assign pend_rs1 = (busy_q[rs1] && !clr_p0[rs1]) || out_hit_rs1_p0;
  assign pend_rs2 = (busy_q[rs2] && !clr_p0[rs2]) || out_hit_rs2_p0;

  // Stage p1: busy vector, set wins over a same-cycle clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
    end else begin
      busy_q <= ((busy_q & ~clr_p0) | set_p0) & ~{{(NUM_GPR-1){1'b0}}, 1'b1};
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/idu_pipe_stage.sv
// Decode-stage pipeline register between IFU and EXU with valid/ready
// handshake, NWB-port operand forwarding and a RAW scoreboard interlock.
// Optional macro IDU_PERF_CNT_EN adds saturating stall/flush counters.
module idu_pipe_stage
  import idu_pipe_stage_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NWB    = 2,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_snxt_pc,
  input  logic [XLEN-1:0]          in_imm,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic                     in_need_rs1,
  input  logic                     in_need_rs2,
  input  logic                     in_wr_rd,
  output logic [REG_IDX_W-1:0]     rf_index_rs1,
  output logic [REG_IDX_W-1:0]     rf_index_rs2,
  input  logic [XLEN-1:0]          rf_data_rs1,
  input  logic [XLEN-1:0]          rf_data_rs2,
  input  logic [NWB-1:0]           wb_en,
  input  logic [NWB*REG_IDX_W-1:0] wb_index,
  input  logic [NWB*XLEN-1:0]      wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_instr,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_snxt_pc,
  output logic [XLEN-1:0]          out_imm,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [REG_IDX_W-1:0]     out_index_rs1,
  output logic [REG_IDX_W-1:0]     out_index_rs2,
  output logic [REG_IDX_W-1:0]     out_index_rd,
  output logic                     out_wr_rd,
  output logic [XLEN-1:0]          out_data_rs1,
  output logic [XLEN-1:0]          out_data_rs2,
  output logic                     hazard_stall
`ifdef IDU_PERF_CNT_EN
  ,
  output logic [31:0]              perf_stall_cnt,
  output logic [31:0]              perf_flush_cnt
`endif
);

  // Lowest-numbered matching write-back port wins; x0 always reads zero
  function automatic logic [XLEN-1:0] fwd_operand(
    input logic [REG_IDX_W-1:0]     rs,
    input logic [XLEN-1:0]          rf,
    input logic [NWB-1:0]           en,
    input logic [NWB*REG_IDX_W-1:0] idx,
    input logic [NWB*XLEN-1:0]      dat
  );
    logic [XLEN-1:0] v;
    v = rf;
    for (int k = NWB - 1; k >= 0; k--) begin
      if (en[k] && (idx[k*REG_IDX_W +: REG_IDX_W] == rs)) begin
        v = dat[k*XLEN +: XLEN];
      end
    end
    if (rs == ZERO_REG) begin
      v = '0;
    end
    return v;
  endfunction

  logic [REG_IDX_W-1:0] rs1_p0;
  logic [REG_IDX_W-1:0] rs2_p0;
  logic [REG_IDX_W-1:0] rd_p0;
  logic [XLEN-1:0]      opnd_rs1_p0;
  logic [XLEN-1:0]      opnd_rs2_p0;
  logic                 pend_rs1_p0;
  logic                 pend_rs2_p0;
  logic                 in_fire_p0;
  logic                 sb_set_p0;
  logic [NUM_GPR-1:0]   sb_busy;

  // Stage p0: field extraction, forwarding and handshake
  assign rs1_p0       = in_instr[19:15];
  assign rs2_p0       = in_instr[24:20];
  assign rd_p0        = in_instr[11:7];
  assign rf_index_rs1 = rs1_p0;
  assign rf_index_rs2 = rs2_p0;

  assign opnd_rs1_p0 = fwd_operand(rs1_p0, rf_data_rs1, wb_en, wb_index, wb_data);
  assign opnd_rs2_p0 = fwd_operand(rs2_p0, rf_data_rs2, wb_en, wb_index, wb_data);

  assign hazard_stall = in_valid && ((in_need_rs1 && pend_rs1_p0) || (in_need_rs2 && pend_rs2_p0));
  assign in_ready     = (!out_valid || out_ready) && !hazard_stall && !flush;
  assign in_fire_p0   = in_valid && in_ready;

  assign sb_set_p0 = out_valid && out_ready && !flush && out_wr_rd && (out_index_rd != ZERO_REG);

  idu_scoreboard #(
    .NWB (NWB)
  ) u_sb (
    .clk       (clk),
    .rstn      (rstn),
    .set_en    (sb_set_p0),
    .set_idx   (out_index_rd),
    .wb_en     (wb_en),
    .wb_index  (wb_index),
    .out_valid (out_valid),
    .out_wr_rd (out_wr_rd),
    .out_rd    (out_index_rd),
    .rs1       (rs1_p0),
    .rs2       (rs2_p0),
    .busy      (sb_busy),
    .pend_rs1  (pend_rs1_p0),
    .pend_rs2  (pend_rs2_p0)
  );

  // Stage p1: output register, flush kills only the held instruction
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid     <= 1'b0;
      out_instr     <= '0;
      out_pc        <= '0;
      out_snxt_pc   <= '0;
      out_imm       <= '0;
      out_ctrl      <= '0;
      out_index_rs1 <= '0;
      out_index_rs2 <= '0;
      out_index_rd  <= '0;
      out_wr_rd     <= 1'b0;
      out_data_rs1  <= '0;
      out_data_rs2  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      out_valid <= in_fire_p0;
      if (in_fire_p0) begin
        out_instr     <= in_instr;
        out_pc        <= in_pc;
        out_snxt_pc   <= in_snxt_pc;
        out_imm       <= in_imm;
        out_ctrl      <= in_ctrl;
        out_index_rs1 <= rs1_p0;
        out_index_rs2 <= rs2_p0;
        out_index_rd  <= rd_p0;
        out_wr_rd     <= in_wr_rd;
        out_data_rs1  <= opnd_rs1_p0;
        out_data_rs2  <= opnd_rs2_p0;
      end
    end
  end

`ifdef IDU_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Stage p1: saturating event counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (hazard_stall) begin
        perf_stall_cnt <= sat_inc(perf_stall_cnt);
      end
      if (flush && out_valid) begin
        perf_flush_cnt <= sat_inc(perf_flush_cnt);
      end
    end
  end
`endif

endmodule
